// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : melody_sequencer
// Brief    : Plays fixed game jingles from an internal ROM as a stream of
//            registered note divisors with beat timing and mute gating.
// Revision : 1.0 - initial release
// ============================================================================
module melody_sequencer #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BEAT_TICKS = 12_500_000,
   parameter int GAP_TICKS  = 1_250_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  tune_sel,
   output logic [19:0] note_div,
   output logic        mute,
   output logic        busy,
   output logic        done
);

   localparam int CNT_W = $clog2(7 * BEAT_TICKS);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_beat = CNT_W'(BEAT_TICKS);
   localparam logic [CNT_W-1:0] c_gap  = CNT_W'(GAP_TICKS);

   // div = CLK_HZ/(2f) - 1, with f in millihertz so the table rounds like the reference
   localparam longint c_clk_x500 = longint'(CLK_HZ) * 500;
   localparam logic [19:0] c_div_a4 = 20'(c_clk_x500 / 440_000 - 1);
   localparam logic [19:0] c_div_c5 = 20'(c_clk_x500 / 523_251 - 1);
   localparam logic [19:0] c_div_e5 = 20'(c_clk_x500 / 659_255 - 1);
   localparam logic [19:0] c_div_g5 = 20'(c_clk_x500 / 783_991 - 1);
   localparam logic [19:0] c_div_c6 = 20'(c_clk_x500 / 1_046_502 - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Entry: {code[2:0], beats[2:0], last}
   function automatic logic [6:0] rom_entry(input logic [1:0] tune, input logic [1:0] idx);
      logic [6:0] e;
      case ({tune, idx})
         4'b00_00: e = {3'd4, 3'd1, 1'b0};
         4'b00_01: e = {3'd2, 3'd1, 1'b1};
         4'b01_00: e = {3'd2, 3'd2, 1'b0};
         4'b01_01: e = {3'd3, 3'd2, 1'b0};
         4'b01_10: e = {3'd4, 3'd2, 1'b0};
         4'b01_11: e = {3'd5, 3'd4, 1'b1};
         4'b10_00: e = {3'd4, 3'd2, 1'b0};
         4'b10_01: e = {3'd3, 3'd2, 1'b0};
         4'b10_10: e = {3'd2, 3'd4, 1'b1};
         4'b11_00: e = {3'd1, 3'd1, 1'b0};
         4'b11_01: e = {3'd0, 3'd1, 1'b0};
         4'b11_10: e = {3'd1, 3'd1, 1'b1};
         default:  e = {3'd0, 3'd1, 1'b1};
      endcase
      return e;
   endfunction

   function automatic logic [19:0] div_of(input logic [2:0] code);
      logic [19:0] d;
      case (code)
         3'd1:    d = c_div_a4;
         3'd2:    d = c_div_c5;
         3'd3:    d = c_div_e5;
         3'd4:    d = c_div_g5;
         3'd5:    d = c_div_c6;
         default: d = 20'd0;
      endcase
      return d;
   endfunction

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_tune, w_tune_nxt;
   logic [1:0]       r_idx, w_idx_nxt;
   logic [2:0]       r_beats, w_beats_nxt;
   logic             r_last, w_last_nxt;
   logic [CNT_W-1:0] r_count, w_count_nxt;
   logic [19:0]      w_div_nxt;
   logic             w_mute_nxt, w_busy_nxt, w_done_nxt;

   logic [1:0]       w_entry_tune, w_entry_idx;
   logic [6:0]       w_entry;
   logic [CNT_W-1:0] w_limit, w_gap_at, w_count_inc;
   logic             w_end, w_load;

   // A start always selects entry 0 of the new tune; otherwise look ahead one entry
   assign w_entry_tune = start ? tune_sel : r_tune;
   assign w_entry_idx  = start ? 2'd0 : r_idx + 2'd1;
   assign w_entry      = rom_entry(w_entry_tune, w_entry_idx);

   assign w_limit     = CNT_W'(r_beats) * c_beat;
   assign w_gap_at    = w_limit - c_gap;
   assign w_count_inc = r_count + c_one;
   assign w_end       = (r_count == w_limit - c_one);

   always_comb begin
      w_state_nxt = r_state;
      w_tune_nxt  = r_tune;
      w_idx_nxt   = r_idx;
      w_beats_nxt = r_beats;
      w_last_nxt  = r_last;
      w_count_nxt = r_count;
      w_div_nxt   = note_div;
      w_mute_nxt  = mute;
      w_busy_nxt  = busy;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;

      if (start) begin
         w_load = 1'b1;
      end else begin
         case (r_state)
            ST_PLAY, ST_GAP: begin
               if (w_end) begin
                  if (r_last) begin
                     w_state_nxt = ST_IDLE;
                     w_idx_nxt   = 2'd0;
                     w_count_nxt = '0;
                     w_div_nxt   = 20'd0;
                     w_mute_nxt  = 1'b1;
                     w_busy_nxt  = 1'b0;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_load = 1'b1;
                  end
               end else begin
                  w_count_nxt = w_count_inc;
                  if (r_state == ST_PLAY && w_count_inc == w_gap_at) begin
                     w_mute_nxt  = 1'b1;
                     w_state_nxt = ST_GAP;
                  end
               end
            end
            default: ;
         endcase
      end

      if (w_load) begin
         w_state_nxt = ST_PLAY;
         w_tune_nxt  = w_entry_tune;
         w_idx_nxt   = w_entry_idx;
         w_beats_nxt = w_entry[3:1];
         w_last_nxt  = w_entry[0];
         w_count_nxt = '0;
         w_div_nxt   = div_of(w_entry[6:4]);
         w_mute_nxt  = (w_entry[6:4] == 3'd0);
         w_busy_nxt  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_tune   <= 2'd0;
         r_idx    <= 2'd0;
         r_beats  <= 3'd0;
         r_last   <= 1'b0;
         r_count  <= '0;
         note_div <= 20'd0;
         mute     <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_tune   <= w_tune_nxt;
         r_idx    <= w_idx_nxt;
         r_beats  <= w_beats_nxt;
         r_last   <= w_last_nxt;
         r_count  <= w_count_nxt;
         note_div <= w_div_nxt;
         mute     <= w_mute_nxt;
         busy     <= w_busy_nxt;
         done     <= w_done_nxt;
      end
   end

endmodule
`default_nettype wire
